decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Second pipeline stage; consumes the 24-bit instruction and next-PC produced by the fetch stage.
- Holds the 16x24 register file with a write-back port.
- Decodes fields and sign-extends the immediate.
- Detects load-use hazards and produces a registered ID/EX bundle for the execute stage.
- Drives the stall back to fetch and honours the branch flush from execute.

Parameters:
DATA_W, 24, datapath and instruction width
NREG, 16, register count; r0 reads 0, writes ignored
LOAD_OP, 4'hA, opcode value that reads data memory
NOP_OP, 4'h0, opcode inserted for bubbles

Ports:
CLK  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
instr_i  in  24  instruction from fetch IR register
pc_next_i  in  24  PC+4 from fetch
valid_i  in  1  instr_i/pc_next_i hold a real instruction
flush_i  in  1  branch taken in execute; kill current decode
wb_en_i  in  1  register write enable from write-back
wb_addr_i  in  4  write-back destination
wb_data_i  in  24  write-back data
stall_o  in/out: out  1  combinational; freeze fetch PC and IR this cycle
ex_valid_o  out  1  ID/EX bundle valid
ex_op_o  out  4  opcode
ex_rd_o  out  4  destination register
ex_rs1_o  out  4  source 1 index (for forwarding)
ex_rs2_o  out  4  source 2 index (for forwarding)
ex_rs1_data_o  out  24  source 1 value
ex_rs2_data_o  out  24  source 2 value
ex_imm_o  out  24  sign-extended immediate
ex_pc_next_o  out  24  PC+4 passed through
ex_is_load_o  out  1  ex_op_o == LOAD_OP

Behaviour:
- Reset (rst=0, async):
  - All ex_* outputs go to 0, with ex_op_o=NOP_OP.
  - All registers r0..r15 go to 0.
  - stall_o is 0 while in reset.
- Field decode:
  - op=instr_i[23:20], rd=[19:16], rs1=[15:12], rs2=[11:8].
  - imm = sign-extend instr_i[11:0] to 24 bits (bit 11 replicated into [23:12]).
- Register file:
  - Write on rising CLK when wb_en_i=1 and wb_addr_i!=0.
  - Reads are combinational.
  - Index 0 always reads 0.
- Write-through bypass: if wb_en_i=1, wb_addr_i!=0 and wb_addr_i==rsX, the read of rsX returns wb_data_i in the same cycle.
- Hazard (combinational):
  - hz = valid_i & ~flush_i & ex_valid_o & ex_is_load_o & (ex_rd_o!=0) & (ex_rd_o==rs1 | ex_rd_o==rs2).
  - Both sources are compared regardless of opcode (conservative).
  - stall_o = hz.
- ID/EX update on every rising CLK, single-cycle latency, priority highest first:
  1. flush_i=1: bubble.
  2. hz=1: bubble. Fetch holds, so the same instruction is re-decoded next cycle.
  3. valid_i=0: bubble.
  4. Otherwise: capture the decoded fields, read data, imm and pc_next_i; ex_valid_o=1.
- Bubble definition: ex_valid_o=0, ex_op_o=NOP_OP, ex_is_load_o=0, all other ex_* fields 0.
- Simultaneous flush and hazard: flush wins and stall_o=0, so fetch is free to load the branch target.
- Stall lasts exactly one cycle per load-use pair, because the bubble clears ex_is_load_o.
- Back-to-back loads to the same rd each create an independent one-cycle stall.
- Reset mid-stall: stall_o drops immediately (async), and the bundle clears.
- Write-back to r0 with wb_en_i=1 has no effect; reads of r0 stay 0.

Test Plan:
- Reset: hold rst=0 with random inputs -> all ex_* =0, ex_op_o=4'h0, stall_o=0. Then release, write nothing, decode rs1=r5 -> ex_rs1_data_o=24'h000000.
- Write-back and bypass:
  - wb_en_i=1, wb_addr_i=3, wb_data_i=24'h00ABCD while instr_i reads rs1=3 -> the next-edge ex_rs1_data_o=24'h00ABCD.
  - The following cycle, with wb_en_i=0, the same read is still 24'h00ABCD.
- Immediate sign-extension:
  - instr_i=24'h1120FF -> ex_imm_o=24'h0000FF, ex_rd_o=1, ex_rs1_o=2.
  - instr_i=24'h112800 -> ex_imm_o=24'hFFF800.
- Load-use stall:
  - Decode load instr_i=24'hA41000 (rd=4), then instr_i=24'h254000 (rs1=4) -> stall_o=1 for one cycle, with ex_valid_o=0 on the next edge.
  - On the following edge, the add is issued with ex_valid_o=1, ex_rs1_o=4, and stall_o=0.
  - Repeat with rd=0 -> no stall.
- Flush priority: create the load-use condition and assert flush_i in the same cycle -> stall_o=0, and the next bundle is a bubble (ex_valid_o=0, ex_op_o=4'h0).
- r0 protection: wb_en_i=1, wb_addr_i=0, wb_data_i=24'hFFFFFF, then decode rs1=0 and rs2=0 -> both data outputs are 24'h000000.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction decode with a 16-entry register file,
// write-through bypass, load-use hazard detection and a registered
// ID/EX bundle for the execute stage.
module decode_stage #(
  parameter int          DATA_W  = 24,
  parameter int          NREG    = 16,
  parameter logic [3:0]  LOAD_OP = 4'hA,
  parameter logic [3:0]  NOP_OP  = 4'h0
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr_i,
  input  logic [DATA_W-1:0] pc_next_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              wb_en_i,
  input  logic [3:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [3:0]        ex_op_o,
  output logic [3:0]        ex_rd_o,
  output logic [3:0]        ex_rs1_o,
  output logic [3:0]        ex_rs2_o,
  output logic [DATA_W-1:0] ex_rs1_data_o,
  output logic [DATA_W-1:0] ex_rs2_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [DATA_W-1:0] ex_pc_next_o,
  output logic              ex_is_load_o
);

  // r0 is hard-wired to zero, so only r1..r(NREG-1) have storage
  logic [DATA_W-1:0] rf_reg [1:NREG-1];

  logic [3:0]        op;
  logic [3:0]        rd;
  logic [3:0]        rs1;
  logic [3:0]        rs2;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              wb_write;
  logic              hz;

  logic              ex_valid_reg;
  logic [3:0]        ex_op_reg;
  logic [3:0]        ex_rd_reg;
  logic [3:0]        ex_rs1_reg;
  logic [3:0]        ex_rs2_reg;
  logic [DATA_W-1:0] ex_rs1_data_reg;
  logic [DATA_W-1:0] ex_rs2_data_reg;
  logic [DATA_W-1:0] ex_imm_reg;
  logic [DATA_W-1:0] ex_pc_next_reg;
  logic              ex_is_load_reg;

  assign op       = instr_i[23:20];
  assign rd       = instr_i[19:16];
  assign rs1      = instr_i[15:12];
  assign rs2      = instr_i[11:8];
  assign imm      = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};
  assign wb_write = wb_en_i && (wb_addr_i != 4'd0);

  // One storage word per architectural register, written from write-back
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_rf
      always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
          rf_reg[gi] <= '0;
        end else if (wb_write && (wb_addr_i == 4'(gi))) begin
          rf_reg[gi] <= wb_data_i;
        end
      end
    end
  endgenerate

  // Read port: r0 is zero, a same-cycle write-back is forwarded
  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] idx);
    logic [DATA_W-1:0] val;
    val = '0;
    if (idx != 4'd0) begin
      if (wb_write && (wb_addr_i == idx)) begin
        val = wb_data_i;
      end else begin
        val = rf_reg[idx];
      end
    end
    return val;
  endfunction

  // Combinational register reads for both sources
  always_comb begin
    rs1_data = read_port(rs1);
    rs2_data = read_port(rs2);
  end

  // Load-use hazard against the instruction now sitting in ID/EX;
  // a flush suppresses it so fetch can redirect to the branch target
  always_comb begin
    hz = valid_i && !flush_i && ex_valid_reg && ex_is_load_reg &&
         (ex_rd_reg != 4'd0) &&
         ((ex_rd_reg == rs1) || (ex_rd_reg == rs2));
  end

  assign stall_o = hz;

  // ID/EX pipeline register: flush, hazard or no input each insert a bubble
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ex_valid_reg    <= 1'b0;
      ex_op_reg       <= NOP_OP;
      ex_rd_reg       <= '0;
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_imm_reg      <= '0;
      ex_pc_next_reg  <= '0;
      ex_is_load_reg  <= 1'b0;
    end else if (flush_i || hz || !valid_i) begin
      ex_valid_reg    <= 1'b0;
      ex_op_reg       <= NOP_OP;
      ex_rd_reg       <= '0;
      ex_rs1_reg      <= '0;
      ex_rs2_reg      <= '0;
      ex_rs1_data_reg <= '0;
      ex_rs2_data_reg <= '0;
      ex_imm_reg      <= '0;
      ex_pc_next_reg  <= '0;
      ex_is_load_reg  <= 1'b0;
    end else begin
      ex_valid_reg    <= 1'b1;
      ex_op_reg       <= op;
      ex_rd_reg       <= rd;
      ex_rs1_reg      <= rs1;
      ex_rs2_reg      <= rs2;
      ex_rs1_data_reg <= rs1_data;
      ex_rs2_data_reg <= rs2_data;
      ex_imm_reg      <= imm;
      ex_pc_next_reg  <= pc_next_i;
      ex_is_load_reg  <= (op == LOAD_OP);
    end
  end

  assign ex_valid_o    = ex_valid_reg;
  assign ex_op_o       = ex_op_reg;
  assign ex_rd_o       = ex_rd_reg;
  assign ex_rs1_o      = ex_rs1_reg;
  assign ex_rs2_o      = ex_rs2_reg;
  assign ex_rs1_data_o = ex_rs1_data_reg;
  assign ex_rs2_data_o = ex_rs2_data_reg;
  assign ex_imm_o      = ex_imm_reg;
  assign ex_pc_next_o  = ex_pc_next_reg;
  assign ex_is_load_o  = ex_is_load_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios plus randomized traffic checked
// against an instruction-level model of the decode stage.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        rst;
  logic [23:0] instr_i;
  logic [23:0] pc_next_i;
  logic        valid_i;
  logic        flush_i;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [23:0] wb_data_i;
  logic        stall_o;
  logic        ex_valid_o;
  logic [3:0]  ex_op_o;
  logic [3:0]  ex_rd_o;
  logic [3:0]  ex_rs1_o;
  logic [3:0]  ex_rs2_o;
  logic [23:0] ex_rs1_data_o;
  logic [23:0] ex_rs2_data_o;
  logic [23:0] ex_imm_o;
  logic [23:0] ex_pc_next_o;
  logic        ex_is_load_o;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  decode_stage dut (
    .CLK(CLK), .rst(rst), .instr_i(instr_i), .pc_next_i(pc_next_i),
    .valid_i(valid_i), .flush_i(flush_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o), .ex_rd_o(ex_rd_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_pc_next_o(ex_pc_next_o),
    .ex_is_load_o(ex_is_load_o)
  );

  // Reference model: architectural register values and the issued instruction
  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [23:0] d1;
    logic [23:0] d2;
    logic [23:0] imm;
    logic [23:0] pcn;
  } issued_t;

  logic [23:0] m_rf [16];
  issued_t     m_ex;

  function automatic issued_t bubble();
    issued_t b;
    b = '{valid: 1'b0, op: 4'h0, rd: 4'h0, rs1: 4'h0, rs2: 4'h0,
          d1: 24'h0, d2: 24'h0, imm: 24'h0, pcn: 24'h0};
    return b;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 24'h0;
    m_ex = bubble();
  endfunction

  function automatic logic [23:0] m_read(input logic [3:0] a);
    if (a == 4'd0) return 24'h0;
    if (wb_en_i && wb_addr_i == a) return wb_data_i;
    return m_rf[a];
  endfunction

  function automatic logic m_stall();
    logic [3:0] s1, s2;
    s1 = instr_i[15:12];
    s2 = instr_i[11:8];
    return valid_i && !flush_i && m_ex.valid && (m_ex.op == 4'hA) &&
           (m_ex.rd != 4'd0) && (m_ex.rd == s1 || m_ex.rd == s2);
  endfunction

  function automatic logic [113:0] m_packed();
    return {m_ex.valid, m_ex.op, m_ex.rd, m_ex.rs1, m_ex.rs2, m_ex.d1,
            m_ex.d2, m_ex.imm, m_ex.pcn, (m_ex.op == 4'hA)};
  endfunction

  // Advance one clock: the model follows the same inputs, sampling is #1 after
  task automatic tick();
    issued_t nx;
    if (flush_i || m_stall() || !valid_i) begin
      nx = bubble();
    end else begin
      nx.valid = 1'b1;
      nx.op    = instr_i[23:20];
      nx.rd    = instr_i[19:16];
      nx.rs1   = instr_i[15:12];
      nx.rs2   = instr_i[11:8];
      nx.d1    = m_read(instr_i[15:12]);
      nx.d2    = m_read(instr_i[11:8]);
      nx.imm   = {{12{instr_i[11]}}, instr_i[11:0]};
      nx.pcn   = pc_next_i;
    end
    @(posedge CLK);
    if (wb_en_i && wb_addr_i != 4'd0) m_rf[wb_addr_i] = wb_data_i;
    m_ex = nx;
    #1;
  endtask

  task automatic drive(input logic [23:0] ins, input logic v, input logic fl);
    instr_i   = ins;
    valid_i   = v;
    flush_i   = fl;
    pc_next_i = $urandom_range(0, 24'hFFFFFF);
    #1;
  endtask

  task automatic test_reset();
    logic [113:0] act;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      instr_i   = $urandom_range(0, 24'hFFFFFF);
      pc_next_i = $urandom_range(0, 24'hFFFFFF);
      valid_i   = 1'b1;
      flush_i   = 1'b0;
      wb_en_i   = 1'b1;
      wb_addr_i = $urandom_range(1, 15);
      wb_data_i = $urandom_range(0, 24'hFFFFFF);
      @(posedge CLK);
      #1;
      act = {ex_valid_o, ex_op_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_next_o, ex_is_load_o};
      checks++;
      if (act !== 114'h0 || stall_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: bundle=%h stall=%b, required all zero", act, stall_o);
      end
    end
    wb_en_i = 1'b0;
    rst = 1'b1;
    drive(24'h115000, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_rs1_data_o !== 24'h000000 || ex_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_r5_read: rs1_data=%h valid=%b, required 000000 1", ex_rs1_data_o, ex_valid_o);
    end
    $display("reset: done");
  endtask

  task automatic test_bypass();
    wb_en_i = 1'b1; wb_addr_i = 4'd3; wb_data_i = 24'h00ABCD;
    drive(24'h213000, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_rs1_data_o !== 24'h00ABCD) begin
      errors++;
      $display("FAIL bypass_same_cycle: rs1_data=%h required 00abcd", ex_rs1_data_o);
    end
    wb_en_i = 1'b0;
    tick();
    checks++;
    if (ex_rs1_data_o !== 24'h00ABCD) begin
      errors++;
      $display("FAIL regfile_read: rs1_data=%h required 00abcd", ex_rs1_data_o);
    end
    $display("bypass: rs1_data=%h", ex_rs1_data_o);
  endtask

  task automatic test_imm();
    drive(24'h1120FF, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_imm_o !== 24'h0000FF || ex_rd_o !== 4'd1 || ex_rs1_o !== 4'd2) begin
      errors++;
      $display("FAIL imm_pos: imm=%h rd=%h rs1=%h required 0000ff 1 2", ex_imm_o, ex_rd_o, ex_rs1_o);
    end
    drive(24'h112800, 1'b1, 1'b0);
    tick();
    checks++;
    if (ex_imm_o !== 24'hFFF800) begin
      errors++;
      $display("FAIL imm_neg: imm=%h required fff800", ex_imm_o);
    end
    $display("imm: last imm=%h", ex_imm_o);
  endtask

  task automatic test_load_use();
    drive(24'hA41000, 1'b1, 1'b0);
    tick();
    drive(24'h254000, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall: stall=%b required 1", stall_o);
    end
    tick();
    checks++;
    if (ex_valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_use_bubble: valid=%b stall=%b required 0 0", ex_valid_o, stall_o);
    end
    tick();
    checks++;
    if (ex_valid_o !== 1'b1 || ex_rs1_o !== 4'd4 || ex_op_o !== 4'h2) begin
      errors++;
      $display("FAIL load_use_issue: valid=%b rs1=%h op=%h required 1 4 2", ex_valid_o, ex_rs1_o, ex_op_o);
    end
    drive(24'hA01000, 1'b1, 1'b0);
    tick();
    drive(24'h250000, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL load_rd0_stall: stall=%b required 0", stall_o);
    end
    tick();
    $display("load_use: done");
  endtask

  task automatic test_flush();
    drive(24'hA41000, 1'b1, 1'b0);
    tick();
    drive(24'h254000, 1'b1, 1'b1);
    checks++;
    if (stall_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: stall=%b required 0", stall_o);
    end
    tick();
    checks++;
    if (ex_valid_o !== 1'b0 || ex_op_o !== 4'h0) begin
      errors++;
      $display("FAIL flush_bubble: valid=%b op=%h required 0 0", ex_valid_o, ex_op_o);
    end
    flush_i = 1'b0;
    $display("flush: done");
  endtask

  task automatic test_r0();
    wb_en_i = 1'b1; wb_addr_i = 4'd0; wb_data_i = 24'hFFFFFF;
    drive(24'h200000, 1'b1, 1'b0);
    tick();
    wb_en_i = 1'b0;
    tick();
    checks++;
    if (ex_rs1_data_o !== 24'h0 || ex_rs2_data_o !== 24'h0) begin
      errors++;
      $display("FAIL r0_read: rs1=%h rs2=%h required 000000 000000", ex_rs1_data_o, ex_rs2_data_o);
    end
    $display("r0: rs1=%h rs2=%h", ex_rs1_data_o, ex_rs2_data_o);
  endtask

  task automatic test_back_to_back();
    drive(24'hA41000, 1'b1, 1'b0);
    tick();
    drive(24'hA44000, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall1: stall=%b required 1", stall_o);
    end
    tick();
    tick();
    checks++;
    if (ex_valid_o !== 1'b1 || ex_is_load_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_load2_issue: valid=%b load=%b required 1 1", ex_valid_o, ex_is_load_o);
    end
    drive(24'h254000, 1'b1, 1'b0);
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stall2: stall=%b required 1", stall_o);
    end
    tick();
    tick();
    $display("back_to_back: done");
  endtask

  task automatic test_reset_mid_stall();
    drive(24'hA41000, 1'b1, 1'b0);
    tick();
    drive(24'h254000, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if (stall_o !== 1'b0 || ex_valid_o !== 1'b0 || ex_is_load_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stall: stall=%b valid=%b load=%b required 0 0 0", stall_o, ex_valid_o, ex_is_load_o);
    end
    #1;
    rst = 1'b1;
    $display("reset_mid_stall: done");
  endtask

  task automatic test_random();
    logic [113:0] act;
    logic [3:0]   op;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'hA : 4'($urandom_range(0, 15));
      instr_i   = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
      pc_next_i = $urandom_range(0, 24'hFFFFFF);
      valid_i   = ($urandom_range(0, 9) != 0);
      flush_i   = ($urandom_range(0, 9) == 0);
      wb_en_i   = $urandom_range(0, 1);
      wb_addr_i = $urandom_range(0, 4);
      wb_data_i = $urandom_range(0, 24'hFFFFFF);
      #1;
      checks++;
      if (stall_o !== m_stall()) begin
        errors++;
        $display("FAIL rand_stall[%0d]: stall=%b required %b", n, stall_o, m_stall());
      end
      tick();
      act = {ex_valid_o, ex_op_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_rs1_data_o,
             ex_rs2_data_o, ex_imm_o, ex_pc_next_o, ex_is_load_o};
      checks++;
      if (act !== m_packed()) begin
        errors++;
        $display("FAIL rand_bundle[%0d]: got=%h required=%h", n, act, m_packed());
      end
    end
    wb_en_i = 1'b0;
    $display("random: 400 cycles done");
  endtask

  initial begin
    rst = 1'b0;
    instr_i = '0; pc_next_i = '0; valid_i = 1'b0; flush_i = 1'b0;
    wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    test_reset();
    test_bypass();
    test_imm();
    test_load_use();
    test_flush();
    test_r0();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
